// File: rtl/input_event_scheduler.sv
// Synchronizes and debounces the 8 button lines, latches each press as a pending
// event and serves pending events round-robin over a valid/ready handshake.
module input_event_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [3:0] CMD_Reg,
  input  logic [3:0] KEY_Reg,
  output logic       EVT_Valid,
  input  logic       EVT_Ready,
  output logic       EVT_IsCmd,
  output logic [1:0] EVT_Index,
  output logic       EVT_Drop,
  output logic [7:0] Pressed
);

  localparam int unsigned NSRC = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NSRC-1:0]  s1_q, s2_q;
  logic [NSRC-1:0]  stable_q, stable_d;
  logic [NSRC-1:0]  stable_dly_q;
  logic [CNT_W-1:0] cnt_q [NSRC];
  logic [CNT_W-1:0] cnt_d [NSRC];
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [2:0]       src_q, src_d;
  logic             drop_q, drop_d;

  logic             grant_found;
  logic [2:0]       grant_idx;
  logic [2:0]       search_idx;
  logic             load;
  logic [NSRC-1:0]  grant_mask;
  logic [NSRC-1:0]  rise;

  // Per-source debounce: a level is accepted only after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NSRC); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Round-robin search starting at ptr, wrapping 7 -> 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    search_idx  = 3'd0;
    for (int i = 0; i < int'(NSRC); i++) begin
      search_idx = ptr_q + 3'(i);
      if (!grant_found && pending_q[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  // Pending/drop bookkeeping and output slot loading; a new rise beats a same-edge grant.
  always_comb begin
    load       = !valid_q || EVT_Ready;
    grant_mask = (load && grant_found) ? (NSRC'(1) << grant_idx) : '0;
    rise       = stable_q & ~stable_dly_q;
    pending_d  = (pending_q & ~grant_mask) | rise;
    drop_d     = |(rise & pending_q & ~grant_mask);
    valid_d    = valid_q;
    src_d      = src_q;
    ptr_d      = ptr_q;
    if (load) begin
      valid_d = grant_found;
      if (grant_found) begin
        src_d = grant_idx;
        ptr_d = grant_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pending_q    <= '0;
      ptr_q        <= '0;
      valid_q      <= 1'b0;
      src_q        <= '0;
      drop_q       <= 1'b0;
      for (int i = 0; i < int'(NSRC); i++) cnt_q[i] <= '0;
    end else begin
      s1_q         <= {CMD_Reg, KEY_Reg};
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      valid_q      <= valid_d;
      src_q        <= src_d;
      drop_q       <= drop_d;
      for (int i = 0; i < int'(NSRC); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign EVT_Valid = valid_q;
  assign EVT_IsCmd = src_q[2];
  assign EVT_Index = src_q[1:0];
  assign EVT_Drop  = drop_q;
  assign Pressed   = stable_q;

endmodule

// File: tb/tb_input_event_scheduler.sv
// Scoreboard bench for input_event_scheduler: expected events are queued by the
// stimulus and popped by a monitor thread on every accepted handshake.
module tb_input_event_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       RST;
  logic [3:0] CMD_Reg;
  logic [3:0] KEY_Reg;
  logic       EVT_Valid;
  logic       EVT_Ready;
  logic       EVT_IsCmd;
  logic [1:0] EVT_Index;
  logic       EVT_Drop;
  logic [7:0] Pressed;

  int         errors = 0;
  int         checks = 0;
  int         drop_cnt = 0;
  int         base;
  logic [2:0] exp_q [$];

  input_event_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .CMD_Reg  (CMD_Reg),
    .KEY_Reg  (KEY_Reg),
    .EVT_Valid(EVT_Valid),
    .EVT_Ready(EVT_Ready),
    .EVT_IsCmd(EVT_IsCmd),
    .EVT_Index(EVT_Index),
    .EVT_Drop (EVT_Drop),
    .Pressed  (Pressed)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    CMD_Reg = 4'h0;
    KEY_Reg = 4'h0;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !EVT_Valid) break;
      tick(1);
    end
    chk("idle_queue", exp_q.size(), 0);
    chk("idle_valid", int'(EVT_Valid), 0);
  endtask

  initial begin
    RST       = 1'b1;
    CMD_Reg   = 4'h0;
    KEY_Reg   = 4'hF;
    EVT_Ready = 1'b1;

    fork
      // Monitor: every accepted handshake must match the oldest expected event.
      forever begin
        @(negedge CLOCK_50);
        if (!RST && EVT_Valid && EVT_Ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", int'({EVT_IsCmd, EVT_Index}), -1);
          end else begin
            chk("event_src", int'({EVT_IsCmd, EVT_Index}), int'(exp_q.pop_front()));
          end
        end
        if (!RST && EVT_Drop) drop_cnt++;
      end
      begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
      end
    join_none

    // Reset with all value keys held
    for (int c = 0; c < 3; c++) begin
      tick(1);
      chk("rst_valid", int'(EVT_Valid), 0);
      chk("rst_pressed", int'(Pressed), 0);
      chk("rst_out", int'({EVT_IsCmd, EVT_Index, EVT_Drop}), 0);
    end
    for (int s = 0; s < 4; s++) exp_q.push_back(3'(s));
    RST = 1'b0;
    tick(7);
    chk("rst_valid_e7", int'(EVT_Valid), 0);
    tick(1);
    chk("rst_valid_e8", int'(EVT_Valid), 1);
    chk("rst_pressed_e8", int'(Pressed), 'h0F);
    for (int s = 1; s < 4; s++) begin
      tick(1);
      chk("rst_burst_valid", int'(EVT_Valid), 1);
    end
    tick(1);
    chk("rst_burst_end", int'(EVT_Valid), 0);
    wait_idle();
    KEY_Reg = 4'h0;
    tick(10);
    chk("rel_pressed", int'(Pressed), 0);

    // Single press with bounce
    do_reset();
    KEY_Reg = 4'b0100;
    tick(1);
    KEY_Reg = 4'b0000;
    tick(1);
    KEY_Reg = 4'b0100;
    exp_q.push_back(3'd2);
    tick(7);
    chk("bounce_e7", int'(EVT_Valid), 0);
    tick(1);
    chk("bounce_e8", int'(EVT_Valid), 1);
    chk("bounce_idx", int'({EVT_IsCmd, EVT_Index}), 2);
    wait_idle();
    KEY_Reg = 4'h0;
    tick(12);
    chk("bounce_release", int'(Pressed), 0);

    // Round-robin across groups
    do_reset();
    CMD_Reg = 4'b1001;
    KEY_Reg = 4'b0010;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd7);
    tick(8);
    for (int k = 0; k < 3; k++) begin
      chk("rr_valid", int'(EVT_Valid), 1);
      tick(1);
    end
    chk("rr_end", int'(EVT_Valid), 0);
    chk("rr_ptr", int'(dut.ptr_q), 0);
    wait_idle();
    CMD_Reg = 4'h0;
    KEY_Reg = 4'h0;
    tick(10);

    // Backpressure holds the presented event
    do_reset();
    EVT_Ready = 1'b0;
    CMD_Reg = 4'b0010;
    exp_q.push_back(3'd5);
    tick(8);
    chk("bp_valid", int'(EVT_Valid), 1);
    KEY_Reg = 4'b0001;
    exp_q.push_back(3'd0);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("bp_hold", int'({EVT_Valid, EVT_IsCmd, EVT_Index}), 'b1101);
    end
    chk("bp_pending0", int'(dut.pending_q[0]), 1);
    EVT_Ready = 1'b1;
    tick(1);
    chk("bp_next", int'({EVT_Valid, EVT_IsCmd, EVT_Index}), 'b1000);
    tick(1);
    chk("bp_done", int'(EVT_Valid), 0);
    wait_idle();
    CMD_Reg = 4'h0;
    KEY_Reg = 4'h0;
    tick(10);

    // Drop: re-press of an already pending source
    do_reset();
    EVT_Ready = 1'b0;
    CMD_Reg = 4'b0001;
    exp_q.push_back(3'd4);
    tick(10);
    KEY_Reg = 4'b1000;
    exp_q.push_back(3'd3);
    tick(10);
    KEY_Reg = 4'b0000;
    tick(8);
    base = drop_cnt;
    KEY_Reg = 4'b1000;
    tick(12);
    chk("drop_pulses", drop_cnt - base, 1);
    chk("drop_hold", int'({EVT_Valid, EVT_IsCmd, EVT_Index}), 'b1100);
    EVT_Ready = 1'b1;
    wait_idle();
    CMD_Reg = 4'h0;
    KEY_Reg = 4'h0;
    tick(10);

    // Mode switch: key moves from value group to command group
    do_reset();
    KEY_Reg = 4'b0010;
    exp_q.push_back(3'd1);
    tick(10);
    chk("mode_pressed_a", int'(Pressed), 'h02);
    KEY_Reg = 4'b0000;
    tick(1);
    CMD_Reg = 4'b0010;
    exp_q.push_back(3'd5);
    tick(4);
    chk("mode_pressed_b", int'(Pressed), 'h02);
    tick(1);
    chk("mode_pressed_c", int'(Pressed), 'h00);
    tick(1);
    chk("mode_pressed_d", int'(Pressed), 'h20);
    wait_idle();
    CMD_Reg = 4'h0;
    tick(10);

    chk("total_drops", drop_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
